quadra_gen: RTL

QUADRA_GEN -- requirements
Module: quadra_gen

---
 rtl/quadra_gen_pkg.sv | 40 ++++
 rtl/quadra_coef_tbl.sv | 64 ++++++
 rtl/quadra_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/quadra_gen_pkg.sv
// Shared constants and types for the quadra_gen piecewise-quadratic evaluator.
// Optional feature macro used by this slice: QUADRA_SAT_EN (output clamp + ovf_cnt).
package quadra_gen_pkg;

    localparam int X_W_DEF      = 24;
    localparam int IDX_W_DEF    = 7;
    localparam int A_W_DEF      = 24;
    localparam int B_W_DEF      = 16;
    localparam int C_W_DEF      = 12;
    localparam int Y_W_DEF      = 24;
    localparam int Y_DROP_DEF   = 0;
    localparam int RND_MODE_DEF = 1;

    localparam int RND_TRUNC = 0;
    localparam int RND_RNE   = 1;

    // Container widths; coefficients/fraction are extended into these so the
    // struct types stay independent of the per-instance parameters.
    localparam int COEF_W = 32;
    localparam int FRAC_W = 32;
    localparam int TERM_W = 64;

    typedef struct packed {
        logic signed [COEF_W-1:0] a;
        logic signed [COEF_W-1:0] b;
        logic signed [COEF_W-1:0] c;
    } coef_t;

    typedef struct packed {
        logic [FRAC_W-1:0] frac;
        coef_t             coef;
    } s1_t;

    typedef struct packed {
        logic signed [TERM_W-1:0] ta;
        logic signed [TERM_W-1:0] tb;
        logic signed [TERM_W-1:0] tc;
    } s2_t;

endpackage

// File: rtl/quadra_coef_tbl.sv
// Coefficient table: 2^IDX_W registered {a,b,c} entries, one write port, combinational read.
// Latency: write visible after the edge; read is same-cycle.
// Backpressure: none, writes always accepted.
module quadra_coef_tbl
    import quadra_gen_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int C_W   = C_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    we,
    input  logic [IDX_W-1:0]        w_idx,
    input  logic signed [A_W-1:0]   w_a,
    input  logic signed [B_W-1:0]   w_b,
    input  logic signed [C_W-1:0]   w_c,
    input  logic [IDX_W-1:0]        r_idx,
    output coef_t                   r_coef
);

    localparam int DEPTH = 1 << IDX_W;

    logic signed [A_W-1:0] a_q [DEPTH];
    logic signed [A_W-1:0] a_d [DEPTH];
    logic signed [B_W-1:0] b_q [DEPTH];
    logic signed [B_W-1:0] b_d [DEPTH];
    logic signed [C_W-1:0] c_q [DEPTH];
    logic signed [C_W-1:0] c_d [DEPTH];

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        if (we) begin
            a_d[w_idx] = w_a;
            b_d[w_idx] = w_b;
            c_d[w_idx] = w_c;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

    always_comb begin
        r_coef   = '0;
        r_coef.a = {{(COEF_W-A_W){a_q[r_idx][A_W-1]}}, a_q[r_idx]};
        r_coef.b = {{(COEF_W-B_W){b_q[r_idx][B_W-1]}}, b_q[r_idx]};
        r_coef.c = {{(COEF_W-C_W){c_q[r_idx][C_W-1]}}, c_q[r_idx]};
    end

endmodule

// File: rtl/quadra_gen.sv
// Segment-indexed quadratic y = (a*2^2F + b*f*2^F + c*f^2) / 2^(2F+Y_DROP), exact then rounded.
// Latency: 3 cycles accept-to-out_valid; full throughput; valid/ready per stage, bubbles collapse.
// Backpressure: out_ready low holds y/out_valid; in_ready drops once all 3 stages hold data. Macro QUADRA_SAT_EN adds clamp + ovf_cnt.
module quadra_gen
    import quadra_gen_pkg::*;
#(
    parameter int X_W      = X_W_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int A_W      = A_W_DEF,
    parameter int B_W      = B_W_DEF,
    parameter int C_W      = C_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int Y_DROP   = Y_DROP_DEF,
    parameter int RND_MODE = RND_MODE_DEF
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [X_W-1:0]          x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [Y_W-1:0]          y,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic signed [A_W-1:0]   cfg_a,
    input  logic signed [B_W-1:0]   cfg_b,
    input  logic signed [C_W-1:0]   cfg_c
`ifdef QUADRA_SAT_EN
    ,
    output logic [15:0]             ovf_cnt
`endif
);

    localparam int F_W = X_W - IDX_W;
    localparam int SH  = 2*F_W + Y_DROP;
    localparam logic [TERM_W-1:0] ONE  = TERM_W'(1);
    localparam logic [TERM_W-1:0] HALF = ONE << (SH-1);
    localparam logic [TERM_W-1:0] MASK = (ONE << SH) - ONE;
    localparam logic signed [TERM_W-1:0] Y_MAX = (ONE << (Y_W-1)) - ONE;
    localparam logic signed [TERM_W-1:0] Y_MIN = ~Y_MAX;

    logic       v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic       rdy1, rdy2, rdy3;
    s1_t        s1_q, s1_d;
    s2_t        s2_q, s2_d;
    logic [Y_W-1:0] y_q, y_d;
    coef_t      rd_coef;

    logic signed [TERM_W-1:0] a64, b64, c64, f64;
    logic signed [TERM_W-1:0] sum, q, res;
    logic [TERM_W-1:0]        rem;
    logic                     sat;
    logic                     unused_res_hi;

    quadra_coef_tbl #(
        .IDX_W (IDX_W),
        .A_W   (A_W),
        .B_W   (B_W),
        .C_W   (C_W)
    ) u_tbl (
        .clk    (clk),
        .rst_b  (rst_b),
        .we     (cfg_we),
        .w_idx  (cfg_idx),
        .w_a    (cfg_a),
        .w_b    (cfg_b),
        .w_c    (cfg_c),
        .r_idx  (x[X_W-1:F_W]),
        .r_coef (rd_coef)
    );

    always_comb begin
        rdy3     = !v3_q || out_ready;
        rdy2     = !v2_q || rdy3;
        rdy1     = !v1_q || rdy2;
        in_ready = rdy1;
        v1_d     = rdy1 ? in_valid : v1_q;
        v2_d     = rdy2 ? v1_q     : v2_q;
        v3_d     = rdy3 ? v2_q     : v3_q;
    end

    // S1 snapshots the table entry at accept, so later writes never reach it.
    always_comb begin
        s1_d = s1_q;
        if (in_valid && rdy1) begin
            s1_d.frac = FRAC_W'(x[F_W-1:0]);
            s1_d.coef = rd_coef;
        end
    end

    always_comb begin
        a64  = {{(TERM_W-COEF_W){s1_q.coef.a[COEF_W-1]}}, s1_q.coef.a};
        b64  = {{(TERM_W-COEF_W){s1_q.coef.b[COEF_W-1]}}, s1_q.coef.b};
        c64  = {{(TERM_W-COEF_W){s1_q.coef.c[COEF_W-1]}}, s1_q.coef.c};
        f64  = {{(TERM_W-FRAC_W){1'b0}}, s1_q.frac};
        s2_d = s2_q;
        if (v1_q && rdy2) begin
            s2_d.ta = a64 <<< (2*F_W);
            s2_d.tb = (b64 * f64) <<< F_W;
            s2_d.tc = c64 * f64 * f64;
        end
    end

    always_comb begin
        sum = s2_q.ta + s2_q.tb + s2_q.tc;
        q   = sum >>> SH;
        rem = sum & MASK;
        if (RND_MODE == RND_RNE && (rem > HALF || (rem == HALF && q[0]))) begin
            q = q + TERM_W'(1);
        end
`ifdef QUADRA_SAT_EN
        if (q > Y_MAX) begin
            res = Y_MAX;
            sat = 1'b1;
        end else if (q < Y_MIN) begin
            res = Y_MIN;
            sat = 1'b1;
        end else begin
            res = q;
            sat = 1'b0;
        end
`else
        res = q;
        sat = 1'b0;
`endif
        unused_res_hi = ^{res[TERM_W-1:Y_W], sat};
        y_d = y_q;
        if (v2_q && rdy3) begin
            y_d = res[Y_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            y_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            y_q  <= y_d;
        end
    end

    assign out_valid = v3_q;
    assign y         = y_q;

`ifdef QUADRA_SAT_EN
    logic        ovf_q, ovf_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_d = ovf_q;
        if (v2_q && rdy3) begin
            ovf_d = sat;
        end
        ovf_cnt_d = ovf_cnt_q;
        if (out_valid && out_ready && ovf_q && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule
